qpsk_demod_frame: RTL and testbench

Parametrised QPSK correlator demodulator with frame acquisition, the successor of the fixed 9-bit / 32-sample demodulator. It sits between the channel model and the decoder. It multiplies decimated channel samples by the local sine and cosine references, integrates over a symbol, and slices the signs into a 2-bit symbol. Unlike its predecessor, sizes are parameters, the decoder handshake is valid/ready with drop detection, head detection uses true magnitude, and frame boundaries are flagged.

---
 rtl/qpsk_demod_frame_if.sv | 30 +++
 rtl/qpsk_demod_frame.sv | 178 +++++++++++++++++
 tb/tb_qpsk_demod_frame.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_demod_frame_if.sv
// Purpose : bundles the sample/reference inputs and the decoder-side symbol
//           handshake of qpsk_demod_frame into one port.
// Ports   : channel_out/GetSin/GetCos (signed DW samples), out_ready (decoder
//           accept) flow from master to slave; demodulation_out, out_valid,
//           frame_start, frame_end, in_frame, sym_drop flow from slave to master.
// Modports: master = channel model + decoder side, slave = demodulator.
interface qpsk_demod_frame_if #(
  parameter int DW = 9
);
  logic signed [DW-1:0] channel_out;
  logic signed [DW-1:0] GetSin;
  logic signed [DW-1:0] GetCos;
  logic [1:0]           demodulation_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 frame_start;
  logic                 frame_end;
  logic                 in_frame;
  logic                 sym_drop;

  modport master (
    output channel_out, GetSin, GetCos, out_ready,
    input  demodulation_out, out_valid, frame_start, frame_end, in_frame, sym_drop
  );

  modport slave (
    input  channel_out, GetSin, GetCos, out_ready,
    output demodulation_out, out_valid, frame_start, frame_end, in_frame, sym_drop
  );
endinterface

// File: rtl/qpsk_demod_frame.sv
// Purpose : QPSK correlator demodulator with frame acquisition; samples the
//           channel every OSR clocks, integrates x*sin / x*cos over SPS
//           samples and slices the two sum signs into a 2-bit symbol.
// Latency : out_valid rises on the edge that takes the last sample of a symbol.
// Backpressure: one-entry output register; a symbol completing while the
//           previous one is still unaccepted is dropped and sym_drop sticks.
// Ports   : clk, reset (sync, active-low); bus (slave modport) carries the
//           samples/references in and the symbol, valid/ready and frame flags.
module qpsk_demod_frame #(
  parameter int DW     = 9,
  parameter int OSR    = 4,
  parameter int SPS    = 32,
  parameter int SYMS   = 32,
  parameter int THRESH = 60,
  parameter int AW     = 2*DW + $clog2(SPS) + 1
) (
  input  logic                clk,
  input  logic                reset,
  qpsk_demod_frame_if.slave   bus
);

  localparam int PW = (OSR  > 1) ? $clog2(OSR)  : 1;
  localparam int SW = $clog2(SPS);
  localparam int YW = (SYMS > 1) ? $clog2(SYMS) : 1;

  localparam logic [PW-1:0] LAST_PHASE = PW'(OSR - 1);
  localparam logic [SW-1:0] LAST_SAMP  = SW'(SPS - 1);
  localparam logic [YW-1:0] LAST_SYM   = YW'(SYMS - 1);
  localparam logic [DW:0]   THR        = (DW+1)'(THRESH);

  typedef enum logic {
    HUNT = 1'b0,
    ACQ  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [SW-1:0]        sample_q, sample_d;
  logic [YW-1:0]        sym_q, sym_d;
  logic signed [AW-1:0] sum_i_q, sum_i_d;
  logic signed [AW-1:0] sum_q_q, sum_q_d;
  logic [1:0]           dat_q, dat_d;
  logic                 vld_q, vld_d;
  logic                 start_q, start_d;
  logic                 fend_q, fend_d;
  logic                 drop_q, drop_d;

  logic                 tick;
  logic signed [DW:0]   x_wide;
  logic [DW:0]          x_mag;
  logic                 head;
  logic signed [AW-1:0] x_ext, sin_ext, cos_ext;
  logic signed [AW-1:0] prod_i, prod_q;
  logic signed [AW-1:0] acc_i, acc_q;
  logic                 sym_done, sym_last;

  // Symbol slicer: sign pair {I,Q} 00->01, 01->11, 10->00, 11->10,
  // which is simply {neg_q, ~neg_i}.
  function automatic logic [1:0] slice_sym(input logic neg_i, input logic neg_q);
    return {neg_q, ~neg_i};
  endfunction

  assign tick = (phase_q == LAST_PHASE);

  // Magnitude in DW+1 bits so the most negative sample maps to +2^(DW-1).
  assign x_wide = {bus.channel_out[DW-1], bus.channel_out};
  assign x_mag  = x_wide[DW] ? $unsigned(-x_wide) : $unsigned(x_wide);
  assign head   = (x_mag > THR);

  assign x_ext   = AW'(bus.channel_out);
  assign sin_ext = AW'(bus.GetSin);
  assign cos_ext = AW'(bus.GetCos);
  assign prod_i  = x_ext * sin_ext;
  assign prod_q  = x_ext * cos_ext;

  // Sums are always zero while hunting, so the same adder serves the head
  // sample and every later sample.
  assign acc_i = sum_i_q + prod_i;
  assign acc_q = sum_q_q + prod_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = tick ? '0 : phase_q + 1'b1;
    sample_d = sample_q;
    sym_d    = sym_q;
    sum_i_d  = sum_i_q;
    sum_q_d  = sum_q_q;
    start_d  = 1'b0;
    sym_done = 1'b0;
    sym_last = 1'b0;

    case (state_q)
      HUNT: begin
        if (tick && head) begin
          state_d  = ACQ;
          start_d  = 1'b1;
          sum_i_d  = acc_i;
          sum_q_d  = acc_q;
          sample_d = SW'(1);
        end
      end
      ACQ: begin
        if (tick) begin
          if (sample_q == LAST_SAMP) begin
            sym_done = 1'b1;
            sum_i_d  = '0;
            sum_q_d  = '0;
            sample_d = '0;
            if (sym_q == LAST_SYM) begin
              sym_last = 1'b1;
              sym_d    = '0;
              state_d  = HUNT;
            end else begin
              sym_d = sym_q + 1'b1;
            end
          end else begin
            sum_i_d  = acc_i;
            sum_q_d  = acc_q;
            sample_d = sample_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // Output register: load when empty or being drained this edge, else drop.
    vld_d  = vld_q;
    dat_d  = dat_q;
    drop_d = drop_q;
    fend_d = sym_done & sym_last;
    if (sym_done) begin
      if (!vld_q || bus.out_ready) begin
        vld_d = 1'b1;
        dat_d = slice_sym(acc_i[AW-1], acc_q[AW-1]);
      end else begin
        drop_d = 1'b1;
      end
    end else if (vld_q && bus.out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= HUNT;
      phase_q  <= '0;
      sample_q <= '0;
      sym_q    <= '0;
      sum_i_q  <= '0;
      sum_q_q  <= '0;
      dat_q    <= '0;
      vld_q    <= 1'b0;
      start_q  <= 1'b0;
      fend_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      sym_q    <= sym_d;
      sum_i_q  <= sum_i_d;
      sum_q_q  <= sum_q_d;
      dat_q    <= dat_d;
      vld_q    <= vld_d;
      start_q  <= start_d;
      fend_q   <= fend_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.demodulation_out = dat_q;
  assign bus.out_valid        = vld_q;
  assign bus.frame_start      = start_q;
  assign bus.frame_end        = fend_q;
  assign bus.in_frame         = (state_q == ACQ);
  assign bus.sym_drop         = drop_q;

endmodule

// File: tb/tb_qpsk_demod_frame.sv
// Bench for qpsk_demod_frame: a frame-level integer reference model compares
// every output each clock, while directed sequences and a vector table check
// the hand-derived corner cases (threshold, quadrants, extremes, drop, reset).
module tb_qpsk_demod_frame;
  localparam int DW       = 9;
  localparam int OSR      = 4;
  localparam int SPS      = 32;
  localparam int SYMS     = 32;
  localparam int THRESH   = 60;
  localparam int SYM_CLKS = SPS * OSR;
  localparam int FIRST_LAT = (SPS - 1) * OSR;  // frame_start to first out_valid

  logic clk = 1'b0;
  logic reset = 1'b0;

  qpsk_demod_frame_if #(.DW(DW)) bus ();

  qpsk_demod_frame #(
    .DW(DW), .OSR(OSR), .SPS(SPS), .SYMS(SYMS), .THRESH(THRESH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.demodulation_out, bus.out_valid, bus.frame_start,
            bus.frame_end, bus.in_frame, bus.sym_drop};
  endfunction

  // ---------------- reference model (frame-level, integer arithmetic) -------
  logic [1:0] qmap [4];
  initial qmap = '{2'b01, 2'b11, 2'b00, 2'b10};  // indexed by {sum_I<0, sum_Q<0}

  int         m_phase, m_k, mx;
  bit         m_acq, m_vld, m_fs, m_fe, m_drop, m_done, m_last;
  logic [1:0] m_sym, m_new;
  longint     m_si, m_sq;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0; m_k = 0; m_acq = 0; m_vld = 0; m_fs = 0; m_fe = 0;
      m_drop = 0; m_sym = 2'b00; m_si = 0; m_sq = 0;
    end else begin
      m_done = 0; m_last = 0; m_fs = 0; m_new = 2'b00;
      if (m_phase == OSR - 1) begin
        mx = int'(bus.channel_out);
        if (!m_acq && ((mx < 0) ? -mx : mx) > THRESH) begin
          m_acq = 1; m_fs = 1; m_k = 0; m_si = 0; m_sq = 0;
        end
        if (m_acq) begin
          m_si += longint'(mx * int'(bus.GetSin));
          m_sq += longint'(mx * int'(bus.GetCos));
          m_k++;
          if (m_k % SPS == 0) begin
            m_done = 1;
            m_new  = qmap[{m_si < 0, m_sq < 0}];
            m_si = 0; m_sq = 0;
            if (m_k == SPS * SYMS) begin
              m_last = 1; m_acq = 0;
            end
          end
        end
      end
      m_phase = (m_phase + 1) % OSR;
      m_fe = m_done && m_last;
      if (m_done) begin
        if (!m_vld || bus.out_ready) begin m_vld = 1; m_sym = m_new; end
        else m_drop = 1;
      end else if (m_vld && bus.out_ready) begin
        m_vld = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("model_outputs", 32'(outs()), 32'({m_sym, m_vld, m_fs, m_fe, m_acq, m_drop}));
  end

  // ---------------- helpers -------------------------------------------------
  function automatic logic sig(input int which);
    return (which == 0) ? bus.frame_start : bus.out_valid;
  endfunction

  task automatic wait_for(input int which, input int limit, output int cyc, output bit ok);
    ok = 0; cyc = 0;
    while (!ok && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (sig(which) === 1'b1) ok = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive(input int x, input int sn, input int cs, input logic rdy);
    bus.channel_out = DW'(x);
    bus.GetSin      = DW'(sn);
    bus.GetCos      = DW'(cs);
    bus.out_ready   = rdy;
  endtask

  typedef struct {
    int         x;
    int         sn;
    int         cs;
    logic [1:0] sym;
  } qvec_t;

  qvec_t tbl [5];

  initial begin
    int         cyc, lat, seen, nvld, fe_idx, fe_cnt, infr_at_fe;
    bit         ok;
    logic [1:0] held;

    // Quadrants at x=+100, plus the extreme-operand case whose sign pair
    // {I>=0, Q<0} = 01 slices to symbol 11.
    tbl[0] = '{100,  100,  100, 2'b01};
    tbl[1] = '{100,  100, -100, 2'b11};
    tbl[2] = '{100, -100,  100, 2'b00};
    tbl[3] = '{100, -100, -100, 2'b10};
    tbl[4] = '{-256, -256, 255, 2'b11};

    drive(0, 0, 0, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs()), 0);
    chk_en = 1'b1;
    reset  = 1'b1;

    // Sub-threshold hunting: +/-60 never starts a frame.
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      drive((i % 2 == 1) ? -60 : 60, 50, 50, 1'b1);
      @(negedge clk);
      if (bus.frame_start === 1'b1 || bus.out_valid === 1'b1) seen++;
    end
    check("subthresh_quiet", 32'(seen), 0);
    drive(61, 50, 50, 1'b1);
    wait_for(0, OSR + 1, cyc, ok);
    check("head61_frame_start", 32'(ok), 1);
    check("head61_in_frame", 32'(bus.in_frame), 1);

    // Table: symbol value, first-symbol latency and symbol period.
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].x, tbl[i].sn, tbl[i].cs, 1'b1);
      do_reset();
      wait_for(0, 2 * OSR, cyc, ok);
      check("tbl_frame_start", 32'(ok), 1);
      wait_for(1, SYM_CLKS + 8, lat, ok);
      check("tbl_first_latency", 32'(lat), 32'(FIRST_LAT));
      check("tbl_symbol", 32'(bus.demodulation_out), 32'(tbl[i].sym));
      @(negedge clk);
      wait_for(1, SYM_CLKS + 8, cyc, ok);
      check("tbl_symbol_period", 32'(cyc + 1), 32'(SYM_CLKS));
    end

    // Full frame: 32 symbols, frame_end on the last, then re-arm on 61.
    drive(100, 100, 100, 1'b1);
    do_reset();
    wait_for(0, 2 * OSR, cyc, ok);
    check("full_frame_start", 32'(ok), 1);
    nvld = 0; fe_idx = -1; fe_cnt = 0; infr_at_fe = -1;
    for (int i = 0; i < SYMS * SYM_CLKS + 64 && fe_cnt == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) nvld++;
      if (bus.frame_end === 1'b1) begin
        fe_cnt++; fe_idx = nvld; infr_at_fe = int'(bus.in_frame);
        drive(0, 100, 100, 1'b1);
      end
    end
    check("full_frame_end_seen", 32'(fe_cnt), 1);
    check("full_frame_end_at_last", 32'(fe_idx), 32'(SYMS));
    check("full_in_frame_low_at_end", 32'(infr_at_fe), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) seen++;
    end
    check("full_idle_no_start", 32'(seen), 0);
    check("full_in_frame_after", 32'(bus.in_frame), 0);
    drive(61, 100, 100, 1'b1);
    wait_for(0, OSR + 1, cyc, ok);
    check("second_frame_start", 32'(ok), 1);

    // Back-pressure: first symbol held, second dropped, then drained.
    drive(100, 100, -100, 1'b0);
    do_reset();
    wait_for(0, 2 * OSR, cyc, ok);
    wait_for(1, SYM_CLKS + 8, cyc, ok);
    check("bp_first_valid", 32'(ok), 1);
    held = bus.demodulation_out;
    check("bp_no_drop_yet", 32'(bus.sym_drop), 0);
    repeat (SYM_CLKS + 4) @(negedge clk);
    check("bp_still_valid", 32'(bus.out_valid), 1);
    check("bp_symbol_held", 32'(bus.demodulation_out), 32'(held));
    check("bp_sym_drop", 32'(bus.sym_drop), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_drained", 32'(bus.out_valid), 0);
    check("bp_drop_sticky", 32'(bus.sym_drop), 1);

    // Reset in symbol 10, then re-acquire from symbol 0.
    drive(100, 100, 100, 1'b1);
    do_reset();
    wait_for(0, 2 * OSR, cyc, ok);
    repeat (10 * SYM_CLKS + 20) @(negedge clk);
    check("mid_in_frame", 32'(bus.in_frame), 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", 32'(outs()), 0);
    reset = 1'b1;
    wait_for(0, 2 * OSR, cyc, ok);
    check("mid_reacquire", 32'(ok), 1);
    wait_for(1, SYM_CLKS + 8, lat, ok);
    check("mid_restart_latency", 32'(lat), 32'(FIRST_LAT));

    // Randomized traffic against the reference model.
    drive(0, 0, 0, 1'b1);
    do_reset();
    for (int b = 0; b < 6; b++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 2500; i++) begin
        int x;
        if (mode == 0) x = int'($urandom_range(0, 2 * THRESH)) - THRESH;
        else if (mode == 1) x = int'($urandom_range(0, 2**DW - 1)) - 2**(DW-1);
        else x = ($urandom_range(0, 1) == 1) ? -(2**(DW-1)) : 2**(DW-1) - 1;
        drive(x, int'($urandom_range(0, 2**DW - 1)), int'($urandom_range(0, 2**DW - 1)),
              ($urandom_range(0, 3) != 0));
        reset = ($urandom_range(0, 2999) != 0);
        @(negedge clk);
      end
    end
    reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
